mult_sequencer: RTL and testbench
=================================

MULT_SEQUENCER -- requirements
Module: mult_sequencer

Interface
REQ-001 The block SHALL have exactly one parameter: ZERO_SKIP, default 1, meaning that when it is 1 a zero operand bypasses iteration.
REQ-002 The block SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-003 clk  in  1  sole clock, all state updates on rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 start  in  1  request a multiply; sampled only in IDLE.
REQ-006 op  in  1  0=MULTU (unsigned), 1=MULT (signed two's complement).
REQ-007 src_a  in  32  multiplicand.
REQ-008 src_b  in  32  multiplier.
REQ-009 ex_a, ex_b  in  32 each  pipeline EX-stage ALU operands.
REQ-010 ex_ctl  in  3  pipeline EX-stage ALU control (010 add, 110 sub, 111 slt, 000 and, 001 or).
REQ-011 alu_a, alu_b  out  32 each  operands driven to the shared ALU.
REQ-012 alu_ctl  out  3  control driven to the shared ALU.
REQ-013 alu_result  in  32  shared ALU result.
REQ-014 alu_zero  in  1  shared ALU zero flag.
REQ-015 busy  out  1  sequencer owns the ALU; the pipeline SHALL stall while it is high.
REQ-016 done  out  1  one-cycle pulse when hi/lo are final.
REQ-017 hi, lo  out  32 each  registered 64-bit product {hi,lo}, held until the next accepted start.

Function
REQ-018 The states SHALL be IDLE, RUN, NEG_LO, NEG_HI and DONE, encoded and registered.
REQ-019 IDLE: alu_a=ex_a, alu_b=ex_b, alu_ctl=ex_ctl (combinational pass-through); busy=0, done=0.
REQ-020 In all other states, ALU ports SHALL be driven only by the sequencer, ex_* SHALL be ignored, and busy=1.
REQ-021 IDLE with start=1 SHALL latch the operands and move to RUN, with these register values:
- mcand=|src_a| if op=1, else src_a;
- lo=|src_b| if op=1, else src_b;
- hi=0; cnt=32;
- neg=op & (src_a[31]^src_b[31]).
REQ-022 The absolute value SHALL be formed internally, not via the ALU; |0x80000000| SHALL equal 0x80000000 unsigned.
REQ-023 ZERO_SKIP=1 and (src_a==0 or src_b==0) at start: go directly to DONE, hi=lo=0, neg cleared.
REQ-024 RUN, one iteration per cycle, drives alu_a=hi, alu_b=mcand, alu_ctl=010.
REQ-025 If lo[0]=1 in RUN:
- c=(alu_result < hi) unsigned;
- hi <= {c, alu_result[31:1]};
- lo <= {alu_result[0], lo[31:1]}.
REQ-026 If lo[0]=0 in RUN: hi <= {1'b0, hi[31:1]}; lo <= {hi[0], lo[31:1]}.
REQ-027 cnt SHALL decrement each RUN cycle; after the 32nd RUN cycle the next state SHALL be NEG_LO if neg=1, else DONE.
REQ-028 NEG_LO SHALL drive alu_a=0, alu_b=lo, alu_ctl=110, then:
- lo <= alu_result;
- lo_zero <= alu_zero;
- next state NEG_HI.
REQ-029 NEG_HI SHALL drive alu_a=0, alu_b=hi, alu_ctl=110, then:
- hi <= lo_zero ? alu_result : ~hi;
- next state DONE.
REQ-030 DONE SHALL assert done=1 and busy=1 for exactly one cycle, then return to IDLE.
REQ-031 Latency, with start accepted at edge N:
- unsigned, or signed with neg=0: done high in cycle N+33;
- signed with neg=1: done high in cycle N+35;
- zero skip: done high in cycle N+1.
REQ-032 start outside IDLE SHALL be ignored, with no queuing; start in the DONE cycle SHALL be ignored.
REQ-033 hi/lo SHALL be updated only in RUN, NEG_LO, NEG_HI and at start acceptance (hi cleared); they SHALL hold in IDLE and DONE.

Reset
REQ-034 rst=1 at a clock edge SHALL force state=IDLE, busy=0, done=0, hi=0, lo=0, cnt=0, neg=0, lo_zero=0, overriding start.
REQ-035 Reset in any state, including mid-RUN, SHALL abort the operation with no done pulse; a start on the first cycle after rst deasserts SHALL be accepted.

Verification
REQ-036 MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done exactly 33 cycles after start; busy high 33 cycles.
REQ-037 MULT -3*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; done at start+35; NEG_LO/NEG_HI seen with alu_ctl=110.
REQ-038 MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0; done at start+33; MULT 5*(-1) -> hi=0xFFFFFFFF, lo=0xFFFFFFFB.
REQ-039 Zero skip (ZERO_SKIP=1): MULTU 0*0x1234 -> done at start+1, hi=lo=0; with ZERO_SKIP=0 -> done at start+33, hi=lo=0.
REQ-040 IDLE with ex_a=5, ex_b=7, ex_ctl=110 -> alu_a=5, alu_b=7, alu_ctl=110, busy=0; in RUN, ex_* toggling has no effect on alu_* or the result.
REQ-041 rst at RUN cycle 10 -> next cycle IDLE, busy=0, hi=lo=0, no done; a start pulsed during RUN is ignored; a follow-up MULTU 6*7 gives lo=42, hi=0.

Source files
------------

// File: rtl/mult_sequencer.sv
// Iterative 32x32 shift-add multiplier that borrows the pipeline's shared ALU.
// Signed products are formed on magnitudes and negated through the ALU at the end.
module mult_sequencer #(
   parameter int ZERO_SKIP = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic [31:0] ex_a,
   input  logic [31:0] ex_b,
   input  logic [2:0]  ex_ctl,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [2:0]  alu_ctl,
   input  logic [31:0] alu_result,
   input  logic        alu_zero,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_RUN    = 3'd1;
   localparam logic [2:0] S_NEG_LO = 3'd2;
   localparam logic [2:0] S_NEG_HI = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   localparam logic [2:0] CTL_ADD = 3'b010;
   localparam logic [2:0] CTL_SUB = 3'b110;

   logic [2:0]  state_q, state_d;
   logic [31:0] mcand_q, mcand_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [5:0]  cnt_q, cnt_d;
   logic        neg_q, neg_d;
   logic        lo_zero_q, lo_zero_d;

   logic [31:0] abs_a, abs_b;
   logic        zero_op;
   logic        carry;

   // Two's-complement negation of 0x80000000 wraps to itself, which is the
   // correct unsigned magnitude.
   assign abs_a   = src_a[31] ? (~src_a + 32'd1) : src_a;
   assign abs_b   = src_b[31] ? (~src_b + 32'd1) : src_b;
   assign zero_op = (src_a == 32'd0) || (src_b == 32'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         mcand_q   <= 32'd0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         cnt_q     <= 6'd0;
         neg_q     <= 1'b0;
         lo_zero_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         cnt_q     <= cnt_d;
         neg_q     <= neg_d;
         lo_zero_q <= lo_zero_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      cnt_d     = cnt_q;
      neg_d     = neg_q;
      lo_zero_d = lo_zero_q;
      carry     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if ((ZERO_SKIP != 0) && zero_op) begin
                  state_d = S_DONE;
                  hi_d    = 32'd0;
                  lo_d    = 32'd0;
                  neg_d   = 1'b0;
               end else begin
                  state_d = S_RUN;
                  mcand_d = op ? abs_a : src_a;
                  lo_d    = op ? abs_b : src_b;
                  hi_d    = 32'd0;
                  cnt_d   = 6'd32;
                  neg_d   = op & (src_a[31] ^ src_b[31]);
               end
            end
         end
         S_RUN: begin
            // The ALU adder has no carry-out, so recover it from the wrap.
            if (lo_q[0]) begin
               carry = (alu_result < hi_q);
               hi_d  = {carry, alu_result[31:1]};
               lo_d  = {alu_result[0], lo_q[31:1]};
            end else begin
               hi_d = {1'b0, hi_q[31:1]};
               lo_d = {hi_q[0], lo_q[31:1]};
            end
            cnt_d = cnt_q - 6'd1;
            if (cnt_q == 6'd1) begin
               state_d = neg_q ? S_NEG_LO : S_DONE;
            end
         end
         S_NEG_LO: begin
            lo_d      = alu_result;
            lo_zero_d = alu_zero;
            state_d   = S_NEG_HI;
         end
         S_NEG_HI: begin
            // Borrow from the low word propagates only when the low word is zero.
            hi_d    = lo_zero_q ? alu_result : ~hi_q;
            state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      alu_a   = ex_a;
      alu_b   = ex_b;
      alu_ctl = ex_ctl;
      busy    = 1'b1;
      done    = 1'b0;
      case (state_q)
         S_IDLE: begin
            busy = 1'b0;
         end
         S_RUN: begin
            alu_a   = hi_q;
            alu_b   = mcand_q;
            alu_ctl = CTL_ADD;
         end
         S_NEG_LO: begin
            alu_a   = 32'd0;
            alu_b   = lo_q;
            alu_ctl = CTL_SUB;
         end
         S_NEG_HI: begin
            alu_a   = 32'd0;
            alu_b   = hi_q;
            alu_ctl = CTL_SUB;
         end
         S_DONE: begin
            alu_a   = 32'd0;
            alu_b   = 32'd0;
            alu_ctl = CTL_ADD;
            done    = 1'b1;
         end
         default: begin
            alu_a   = 32'd0;
            alu_b   = 32'd0;
            alu_ctl = CTL_ADD;
         end
      endcase
   end

   assign hi = hi_q;
   assign lo = lo_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer: a behavioural ALU closes the loop for two
// instances, one with zero skip enabled and one without.
module tb_mult_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start0, start1;
   logic        op;
   logic [31:0] src_a, src_b;
   logic [31:0] ex_a, ex_b;
   logic [2:0]  ex_ctl;

   logic [31:0] alu_a0, alu_b0, alu_res0, hi0, lo0;
   logic [2:0]  alu_ctl0;
   logic        alu_zero0, busy0, done0;
   logic [31:0] alu_a1, alu_b1, alu_res1, hi1, lo1;
   logic [2:0]  alu_ctl1;
   logic        alu_zero1, busy1, done1;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] ctl);
      case (ctl)
         3'b010:  return a + b;
         3'b110:  return a - b;
         3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'b000:  return a & b;
         3'b001:  return a | b;
         default: return 32'd0;
      endcase
   endfunction

   assign alu_res0  = alu_f(alu_a0, alu_b0, alu_ctl0);
   assign alu_zero0 = (alu_res0 == 32'd0);
   assign alu_res1  = alu_f(alu_a1, alu_b1, alu_ctl1);
   assign alu_zero1 = (alu_res1 == 32'd0);

   mult_sequencer #(.ZERO_SKIP(1)) dut0 (
      .clk(clk), .rst(rst), .start(start0), .op(op), .src_a(src_a), .src_b(src_b),
      .ex_a(ex_a), .ex_b(ex_b), .ex_ctl(ex_ctl),
      .alu_a(alu_a0), .alu_b(alu_b0), .alu_ctl(alu_ctl0),
      .alu_result(alu_res0), .alu_zero(alu_zero0),
      .busy(busy0), .done(done0), .hi(hi0), .lo(lo0)
   );

   mult_sequencer #(.ZERO_SKIP(0)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .op(op), .src_a(src_a), .src_b(src_b),
      .ex_a(ex_a), .ex_b(ex_b), .ex_ctl(ex_ctl),
      .alu_a(alu_a1), .alu_b(alu_b1), .alu_ctl(alu_ctl1),
      .alu_result(alu_res1), .alu_zero(alu_zero1),
      .busy(busy1), .done(done1), .hi(hi1), .lo(lo1)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_start(input bit sel, input logic v);
      if (sel) start1 = v;
      else     start0 = v;
   endtask

   // Issues start at the current time; the next rising edge is edge N.
   task automatic run_mul(input string tag, input bit sel, input logic opv,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input int exp_lat);
      int k;
      int busy_n;
      int neg_n;
      logic [31:0] r_hi, r_lo;
      op = opv; src_a = a; src_b = b;
      set_start(sel, 1'b1);
      @(posedge clk); #1;
      set_start(sel, 1'b0);
      k = 1; busy_n = 0; neg_n = 0;
      while (k <= 60) begin
         if (sel ? busy1 : busy0) busy_n++;
         if ((sel ? busy1 : busy0) && ((sel ? alu_ctl1 : alu_ctl0) == 3'b110)) neg_n++;
         if (k == 1 && exp_lat > 1) begin
            check({tag, "_run_ctl"}, {61'd0, (sel ? alu_ctl1 : alu_ctl0)}, 64'd2);
            check({tag, "_run_alu_a"}, {32'd0, (sel ? alu_a1 : alu_a0)}, 64'd0);
         end
         if (sel ? done1 : done0) break;
         ex_a = $urandom; ex_b = $urandom; ex_ctl = 3'($urandom_range(0, 7));
         if (k == 5) begin
            set_start(sel, 1'b1); src_a = 32'd0; src_b = 32'd3; op = ~opv;
         end
         if (k == 6) set_start(sel, 1'b0);
         @(posedge clk); #1;
         k++;
      end
      r_hi = sel ? hi1 : hi0;
      r_lo = sel ? lo1 : lo0;
      $display("%s: a=%h b=%h op=%0d -> hi=%h lo=%h latency=%0d", tag, a, b, opv, r_hi, r_lo, k);
      check({tag, "_latency"}, 64'(k), 64'(exp_lat));
      check({tag, "_busy_cycles"}, 64'(busy_n), 64'(exp_lat));
      check({tag, "_neg_ctl_cycles"}, 64'(neg_n), (exp_lat == 35) ? 64'd2 : 64'd0);
      check({tag, "_product"}, {r_hi, r_lo}, {exp_hi, exp_lo});
      // A start presented in the DONE cycle must be dropped.
      set_start(sel, 1'b1);
      @(posedge clk); #1;
      set_start(sel, 1'b0);
      check({tag, "_idle_after_done"}, {62'd0, (sel ? busy1 : busy0), (sel ? done1 : done0)}, 64'd0);
   endtask

   initial begin
      int k;
      rst = 1'b1; start0 = 1'b0; start1 = 1'b0; op = 1'b0;
      src_a = 32'd0; src_b = 32'd0; ex_a = 32'd0; ex_b = 32'd0; ex_ctl = 3'b000;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", {63'd0, busy0}, 64'd0);
      check("reset_done", {63'd0, done0}, 64'd0);
      check("reset_hilo", {hi0, lo0}, 64'd0);
      rst = 1'b0;
      ex_a = 32'd5; ex_b = 32'd7; ex_ctl = 3'b110;
      @(posedge clk); #1;
      $display("passthrough: alu_a=%h alu_b=%h alu_ctl=%b busy=%b", alu_a0, alu_b0, alu_ctl0, busy0);
      check("pass_alu_a", {32'd0, alu_a0}, 64'd5);
      check("pass_alu_b", {32'd0, alu_b0}, 64'd7);
      check("pass_alu_ctl", {61'd0, alu_ctl0}, 64'd6);
      check("pass_busy", {63'd0, busy0}, 64'd0);

      run_mul("multu_max", 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33);
      repeat (3) @(posedge clk);
      #1;
      check("hold_in_idle", {hi0, lo0}, 64'hFFFFFFFE_00000001);
      run_mul("mult_m3x7", 1'b0, 1'b1, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 35);
      run_mul("mult_minxmin", 1'b0, 1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33);
      run_mul("mult_5xm1", 1'b0, 1'b1, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFB, 35);
      run_mul("zskip_on", 1'b0, 1'b0, 32'd0, 32'h1234, 32'd0, 32'd0, 1);
      run_mul("zskip_off", 1'b1, 1'b0, 32'd0, 32'h1234, 32'd0, 32'd0, 33);

      // Abort a run with reset at RUN cycle 10, then start immediately after.
      op = 1'b0; src_a = 32'hFFFFFFFF; src_b = 32'hFFFFFFFF;
      start0 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0;
      for (k = 1; k < 10; k++) begin
         @(posedge clk); #1;
      end
      check("abort_busy_before", {63'd0, busy0}, 64'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      $display("abort: busy=%b done=%b hi=%h lo=%h", busy0, done0, hi0, lo0);
      check("abort_busy_done", {62'd0, busy0, done0}, 64'd0);
      check("abort_hilo", {hi0, lo0}, 64'd0);
      run_mul("multu_6x7", 1'b0, 1'b0, 32'd6, 32'd7, 32'd0, 32'd42, 33);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
